router_out_arb: RTL and testbench
=================================

# router_out_arb

Clocked output-port arbiter and buffer for one mesh router direction. It merges the up-to-four router input stages that can target one output link into a single stream and buffers packets in a small FIFO. Example: the East output is fed by the N, S, W and PE input stages. Each router instantiates one per output link (N, S, E, W, PE). Packets pass through unmodified; coordinate updates are done upstream in the per-direction routing stages.

## Interface
- WIDTH, 35, packet width: [34:33] src_x, [32:31] src_y, [30:29] dst_x, [28:27] dst_y, [26:0] payload
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- NIN, 4, number of input requesters (fixed at 4 in this release)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  NIN  per-input packet valid
- in_data  input  NIN*WIDTH  packet of input i on bits [i*WIDTH +: WIDTH]
- in_ready  output  NIN  per-input accept; a transfer occurs when in_valid[i] && in_ready[i] at a clock edge
- out_valid  output  1  FIFO head valid
- out_data  output  WIDTH  FIFO head packet
- out_ready  input  1  downstream accept; pop when out_valid && out_ready
- fwd_cnt  output  16  count of packets popped on the output, wraps at 2^16

## Operation
- State:
  - FIFO storage, rd_ptr, wr_ptr, count (0..DEPTH)
  - rr_ptr (2 bits)
  - fwd_cnt
- Grant (combinational):
  - Scan indices rr_ptr, rr_ptr+1, … mod 4.
  - The first index with in_valid set is granted; none if no input is valid.
- in_ready[i] = 1 only when i is granted and count < DEPTH and rst is 0. At most one bit is set.
- Push: on a granted handshake, write in_data[grant] at wr_ptr. Then wr_ptr+1 mod DEPTH and rr_ptr ← grant+1 mod 4.
- Pointer hold:
  - rr_ptr is unchanged when no push occurs.
  - A valid-but-unaccepted input keeps priority position; it is not skipped.
- Pop: on an output handshake, rd_ptr+1 mod DEPTH and fwd_cnt+1.
- Push and pop in the same cycle: count unchanged.
- out_valid = (count != 0); out_data = entry at rd_ptr (first-word-fall-through from registered storage).
- Ordering:
  - Packets from one input leave in arrival order.
  - Across inputs, order is acceptance order.
- Protocol requirements on neighbours:
  - Upstream must hold in_valid/in_data stable until accepted.
  - in_ready may depend combinationally on in_valid; in_valid must not depend on in_ready.
  - out_valid/out_data are register-driven only.
- Fairness: with all four inputs continuously valid and out_ready=1, grants rotate 0,1,2,3,0…, so each input is served once per 4 accepts.

## Timing
- Reset (rst=1 at an edge): count=0, rd_ptr=wr_ptr=0, rr_ptr=0, fwd_cnt=0.
  - Outputs after reset: out_valid=0, in_ready=0. FIFO contents are don't-care.
  - in_ready is forced 0 combinationally while rst=1.
- Reset mid-operation:
  - Buffered packets are discarded.
  - No handshake is counted on the reset edge.
  - out_valid=0 in the following cycle.
- Latency: a packet accepted at edge t is presented on out_data with out_valid=1 from edge t (visible in cycle t+1). Minimum one-cycle fall-through.
- Throughput: one packet per cycle sustained with out_ready=1 (count toggles 0↔1 or holds).
- Full boundary:
  - count=DEPTH gives in_ready=0, even if out_ready=1 that cycle; no full-bypass.
  - Acceptance resumes the cycle after a pop.
- Empty boundary: count=0 gives out_valid=0. out_ready is ignored.
- Wrap-around: pointers wrap mod DEPTH; fwd_cnt wraps 0xFFFF→0x0000.

## Test plan
- Reset: hold rst 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, fwd_cnt=0 throughout; first accept is input 0 in the cycle after rst falls.
- Single input: input 2 sends 0x1_2345_6789, out_ready=1 -> in_ready=0100 for one cycle; out_data equals the packet next cycle; fwd_cnt=1.
- Round-robin: all 4 inputs valid with distinct packets, out_ready=1 for 8 cycles -> output source order 0,1,2,3,0,1,2,3; fwd_cnt=8.
- Backpressure/full: out_ready=0, inputs 1 and 3 valid -> accepts input 1, then input 3, then in_ready=0000 (count=2). Raise out_ready -> input 1 packet leaves first, and acceptance resumes one cycle after the first pop.
- Reset mid-stream: FIFO holding 2 packets, assert rst for one edge -> out_valid=0 next cycle, fwd_cnt=0, and the old packets never appear.
- Counter wrap: preload via 65,537 single-input transfers -> fwd_cnt reads 0x0001.

Source files
------------

// File: rtl/router_out_arb.sv
// ---------------------------------------------------------------------------
// router_out_arb
//
// Output-port arbiter and packet buffer for one mesh router direction.
// Up to NIN input stages compete for one output link. A round-robin arbiter
// picks one valid input per cycle and writes its packet into a small FIFO.
// The FIFO head drives the output link. Packets pass through unmodified.
//
// Handshake semantics (applies to every valid/ready pair on this block):
//   A transfer happens at a rising clock edge when valid && ready are both 1.
//   The producer holds valid and data stable until that transfer happens.
//   valid never depends on ready. ready may depend combinationally on valid:
//   in_ready is a function of in_valid.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   [NIN]         per-input packet valid
//   in_data    [NIN*WIDTH]   packet of input i on bits [i*WIDTH +: WIDTH]
//   in_ready   [NIN]         one-hot accept for the granted input (or zero)
//   out_valid                FIFO holds at least one packet
//   out_data   [WIDTH]       packet at the FIFO head (first-word fall-through)
//   out_ready                downstream accept; a pop happens on valid && ready
//   fwd_cnt    [16]          packets popped on the output, wraps at 2^16
// ---------------------------------------------------------------------------
module router_out_arb #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 2,
  parameter int NIN   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NIN-1:0]       in_valid,
  input  logic [NIN*WIDTH-1:0] in_data,
  output logic [NIN-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [15:0]          fwd_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RR_W  = (NIN > 1) ? $clog2(NIN) : 1;

  // FIFO state
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // Arbitration state and decode
  logic [RR_W-1:0]  rr_ptr;
  logic [RR_W-1:0]  grant_idx;
  logic [RR_W-1:0]  scan_idx;
  logic             grant_valid;
  logic [WIDTH-1:0] sel_data;

  logic full;
  logic push;
  logic pop;

  // -------------------------------------------------------------------------
  // Round-robin grant. The scan starts at rr_ptr and moves upward modulo NIN.
  // The loop runs from the farthest offset down to offset 0. A later
  // assignment overrides an earlier one, so the valid input closest to rr_ptr
  // wins. NIN is a power of two, so the pointer wraps by plain overflow.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    scan_idx    = rr_ptr;
    for (int k = NIN - 1; k >= 0; k--) begin
      scan_idx = rr_ptr + RR_W'(k);
      if (in_valid[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Select the granted input's packet for the FIFO write port.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NIN; i++) begin
      if (grant_idx == RR_W'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // A full FIFO blocks acceptance even if a pop happens in the same cycle.
  // There is no full-bypass path, so in_ready never depends on out_ready.
  assign full = (count == CNT_W'(DEPTH));
  assign push = grant_valid && !full && !rst;
  assign pop  = out_valid && out_ready;

  always_comb begin
    in_ready = '0;
    if (push) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage. It has no reset: the contents only matter where count says
  // an entry is live.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sel_data;
    end
  end

  // -------------------------------------------------------------------------
  // Pointers, occupancy, rotation and the forward counter. Reset takes
  // priority, so a handshake that coincides with the reset edge is dropped
  // and not counted.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      rr_ptr  <= '0;
      fwd_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        // The winner moves to the back of the rotation. Without a push the
        // pointer holds, so a waiting input keeps its priority position.
        rr_ptr <= grant_idx + RR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        fwd_cnt <= fwd_cnt + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The head is read straight from registered storage. A packet written at
  // edge t is visible on out_data in the cycle after t.
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

endmodule

// File: tb/tb_router_out_arb.sv
// ---------------------------------------------------------------------------
// tb_router_out_arb
//
// Self-checking bench for router_out_arb. The driver applies per-lane packets
// at the falling edge. It predicts the grant from a round-robin reference,
// checks in_ready, out_valid and fwd_cnt, and pushes every predicted accept
// into exp_q. An independent monitor pops exp_q on each output handshake and
// compares out_data against the popped packet.
// ---------------------------------------------------------------------------
module tb_router_out_arb;
  localparam int WIDTH = 35;
  localparam int DEPTH = 2;
  localparam int NIN   = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic [NIN-1:0]       in_valid = '0;
  logic [NIN*WIDTH-1:0] in_data  = '0;
  logic [NIN-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_ready = 1'b0;
  logic [15:0]          fwd_cnt;

  router_out_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NIN(NIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .fwd_cnt   (fwd_cnt)
  );

  // Scoreboard and reference state
  logic [WIDTH-1:0] exp_q[$];
  int               compared   = 0;
  int               mismatched = 0;
  int               rr_model   = 0;
  logic [15:0]      fwd_exp    = '0;

  // Lane stimulus state, applied by step()
  logic             lane_valid [NIN];
  logic [WIDTH-1:0] lane_data  [NIN];
  logic             rst_drv  = 1'b1;
  logic             ordy_drv = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference grant: the first valid lane scanning upward from rr_model.
  function automatic int model_grant();
    for (int k = 0; k < NIN; k++) begin
      int idx;
      idx = (rr_model + k) % NIN;
      if (lane_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] rand_pkt();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[WIDTH-1:0];
  endfunction

  task automatic clear_lanes();
    for (int i = 0; i < NIN; i++) lane_valid[i] = 1'b0;
  endtask

  // Driver: one clock cycle. It applies the inputs, checks the outputs and
  // updates the reference.
  task automatic step();
    int g;
    logic [NIN-1:0] exp_rdy;
    @(negedge clk);
    rst       = rst_drv;
    out_ready = ordy_drv;
    for (int i = 0; i < NIN; i++) begin
      in_valid[i]                 = lane_valid[i];
      in_data[i*WIDTH +: WIDTH]   = lane_data[i];
    end
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (!rst_drv && g >= 0 && exp_q.size() < DEPTH) exp_rdy[g] = 1'b1;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_q.size() != 0);
    check("fwd_cnt", fwd_cnt, fwd_exp);
    if (rst_drv) begin
      exp_q.delete();
      rr_model = 0;
      fwd_exp  = '0;
    end else if (exp_rdy != '0) begin
      exp_q.push_back(lane_data[g]);
      rr_model = (g + 1) % NIN;
      lane_valid[g] = 1'b0;
    end
  endtask

  // Monitor: consumes one expected packet per output handshake.
  initial begin
    logic [WIDTH-1:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_pop: got %0h expected no packet at %0t", out_data, $time);
        end else begin
          exp = exp_q.pop_front();
          check("out_data", out_data, exp);
          fwd_exp = fwd_exp + 16'd1;
        end
      end
    end
  end

  // Test sequence
  initial begin
    for (int i = 0; i < NIN; i++) begin
      lane_valid[i] = 1'b0;
      lane_data[i]  = '0;
    end

    // Reset held for 2 cycles with all inputs valid
    for (int i = 0; i < NIN; i++) begin
      lane_valid[i] = 1'b1;
      lane_data[i]  = rand_pkt();
    end
    rst_drv = 1'b1; ordy_drv = 1'b0;
    repeat (2) begin
      step();
      check("reset_in_ready", in_ready, 4'b0000);
    end
    rst_drv = 1'b0; ordy_drv = 1'b1;
    step();
    check("first_grant", in_ready, 4'b0001);
    clear_lanes();
    repeat (3) step();

    // Single packet on input 2
    lane_valid[2] = 1'b1;
    lane_data[2]  = 35'h1_2345_6789;
    step();
    check("single_grant", in_ready, 4'b0100);
    repeat (3) step();

    // Round-robin with all four inputs valid
    rst_drv = 1'b1; step(); rst_drv = 1'b0;
    ordy_drv = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NIN; i++) begin
        if (!lane_valid[i]) begin
          lane_valid[i] = 1'b1;
          lane_data[i]  = {3'(i), 32'(c)};
        end
      end
      step();
      check("rr_grant", in_ready, 4'b0001 << (c % 4));
    end
    clear_lanes();
    repeat (3) step();
    check("rr_fwd_cnt", fwd_cnt, 16'd8);

    // Backpressure until full, then release
    rst_drv = 1'b1; step(); rst_drv = 1'b0;
    ordy_drv = 1'b0;
    lane_valid[1] = 1'b1; lane_data[1] = rand_pkt();
    lane_valid[3] = 1'b1; lane_data[3] = rand_pkt();
    step();
    check("bp_first", in_ready, 4'b0010);
    step();
    check("bp_second", in_ready, 4'b1000);
    lane_valid[0] = 1'b1; lane_data[0] = rand_pkt();
    step();
    check("bp_full", in_ready, 4'b0000);
    ordy_drv = 1'b1;
    step();
    check("bp_full_pop", in_ready, 4'b0000);
    step();
    check("bp_resume", in_ready, 4'b0001);
    clear_lanes();
    repeat (4) step();

    // Reset with two packets buffered
    ordy_drv = 1'b0;
    lane_valid[0] = 1'b1; lane_data[0] = rand_pkt();
    lane_valid[1] = 1'b1; lane_data[1] = rand_pkt();
    repeat (2) step();
    clear_lanes();
    rst_drv = 1'b1; step(); rst_drv = 1'b0;
    ordy_drv = 1'b1;
    step();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_fwd_cnt", fwd_cnt, 16'd0);
    repeat (3) step();

    // Random traffic with random backpressure and occasional reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NIN; i++) begin
        if (!lane_valid[i] && $urandom_range(0, 2) == 0) begin
          lane_valid[i] = 1'b1;
          lane_data[i]  = rand_pkt();
        end
      end
      ordy_drv = ($urandom_range(0, 3) != 0);
      rst_drv  = ($urandom_range(0, 299) == 0);
      step();
    end
    rst_drv = 1'b0; ordy_drv = 1'b1;
    clear_lanes();
    repeat (4) step();

    // Counter wrap: 65537 transfers through a single input
    rst_drv = 1'b1; step(); rst_drv = 1'b0;
    ordy_drv = 1'b1;
    for (int c = 0; c < 65537; c++) begin
      lane_valid[1] = 1'b1;
      lane_data[1]  = rand_pkt();
      step();
    end
    clear_lanes();
    repeat (3) step();
    check("wrap_fwd_cnt", fwd_cnt, 16'h0001);
    check("drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
